// File: rtl/gpio_in_debounce_pkg.sv
// Shared types and helpers for the GPIO input debouncer.
// Channel FSM states and the counter-width helper used by every channel.
package gpio_debounce_pkg;

  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

  // Wide enough to hold DEBOUNCE_CYCLES itself, so the count can never wrap.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_in_debounce_if.sv
// Bus bundle between the board-side driver and the debouncer.
// The debouncer sits on the slave modport.
interface gpio_in_debounce_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] RAW_IN;
  logic [WIDTH-1:0] IRQ_MASK;
  logic [WIDTH-1:0] IRQ_CLR;
  logic [WIDTH-1:0] CLEAN_OUT;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic [WIDTH-1:0] IRQ_PEND;
  logic             CHANGE_IRQ;

  modport master (
    output RAW_IN, IRQ_MASK, IRQ_CLR,
    input  CLEAN_OUT, RISE, FALL, IRQ_PEND, CHANGE_IRQ
  );

  modport slave (
    input  RAW_IN, IRQ_MASK, IRQ_CLR,
    output CLEAN_OUT, RISE, FALL, IRQ_PEND, CHANGE_IRQ
  );

endinterface

// File: rtl/gpio_in_debounce_bit.sv
// One debounced channel: synchroniser, stability counter, clean level and edge pulses.
// edge_next is the unregistered next-state edge, so pending flags can set alongside the pulse.
module debounce_bit
  import gpio_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic HCLK,
  input  logic RESET,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic edge_next
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_d, rise_d, fall_d;

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      clean   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean   <= clean_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Any sample matching the clean level before the count completes restarts the wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (s != clean) begin
          state_d = DB_COUNTING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      DB_COUNTING: begin
        if (s == clean) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          clean_d = s;
          rise_d  = s;
          fall_d  = ~s;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  assign edge_next = rise_d | fall_d;

endmodule

// File: rtl/gpio_in_debounce.sv
// Switch input conditioner feeding GPIOIN: per-bit debounce plus sticky, maskable change interrupt.
// All outputs are registered; nothing passes combinationally from an input to an output.
module gpio_in_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                HCLK,
  input  logic                RESET,
  gpio_in_debounce_if.slave   bus
);

  logic [WIDTH-1:0] clean_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] edge_next_vec;
  logic [WIDTH-1:0] pend_q;
  logic             change_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .HCLK      (HCLK),
      .RESET     (RESET),
      .raw       (bus.RAW_IN[g]),
      .clean     (clean_vec[g]),
      .rise      (rise_vec[g]),
      .fall      (fall_vec[g]),
      .edge_next (edge_next_vec[g])
    );
  end

  // A new masked edge outranks a simultaneous clear so no event is ever lost.
  always_ff @(posedge HCLK) begin
    if (RESET) begin
      pend_q   <= '0;
      change_q <= 1'b0;
    end else begin
      pend_q   <= (pend_q & ~bus.IRQ_CLR) | (edge_next_vec & bus.IRQ_MASK);
      change_q <= |pend_q;
    end
  end

  assign bus.CLEAN_OUT  = clean_vec;
  assign bus.RISE       = rise_vec;
  assign bus.FALL       = fall_vec;
  assign bus.IRQ_PEND   = pend_q;
  assign bus.CHANGE_IRQ = change_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with a 4-cycle debounce window and 2-stage synchroniser.
// Inputs change 1 time unit after a rising edge and outputs are checked at that same point.
module tb_gpio_in_debounce;

  logic HCLK;
  logic RESET;
  int   check_count;
  int   error_count;

  gpio_in_debounce_if #(.WIDTH(16)) gpio_bus ();

  gpio_in_debounce #(
    .WIDTH           (16),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .HCLK  (HCLK),
    .RESET (RESET),
    .bus   (gpio_bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic applyStimulus(input logic [15:0] raw, input logic [15:0] mask,
                               input logic [15:0] clr);
    gpio_bus.RAW_IN   = raw;
    gpio_bus.IRQ_MASK = mask;
    gpio_bus.IRQ_CLR  = clr;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    RESET = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 16'h0000);

    // Reset held with idle inputs
    for (int i = 0; i < 20; i++) begin
      stepCycles(1);
      checkOutput("reset_clean", gpio_bus.CLEAN_OUT, 32'h0);
      checkOutput("reset_edges", {gpio_bus.RISE, gpio_bus.FALL}, 32'h0);
      checkOutput("reset_irq", gpio_bus.CHANGE_IRQ, 32'h0);
    end

    // Bit 0 rises at reset release; accepted six edges later
    RESET = 1'b0;
    applyStimulus(16'h0001, 16'h0001, 16'h0000);
    stepCycles(5);
    checkOutput("rise0_early_clean", gpio_bus.CLEAN_OUT, 32'h0000);
    stepCycles(1);
    checkOutput("rise0_clean", gpio_bus.CLEAN_OUT, 32'h0001);
    checkOutput("rise0_rise", gpio_bus.RISE, 32'h0001);
    checkOutput("rise0_pend", gpio_bus.IRQ_PEND, 32'h0001);
    checkOutput("rise0_irq_lag", gpio_bus.CHANGE_IRQ, 32'h0);
    stepCycles(1);
    checkOutput("rise0_rise_end", gpio_bus.RISE, 32'h0000);
    checkOutput("rise0_irq", gpio_bus.CHANGE_IRQ, 32'h1);

    // 3-cycle glitch on bit 3 is rejected; mask cleared must not drop bit 0's flag
    applyStimulus(16'h0009, 16'h0000, 16'h0000);
    for (int i = 1; i <= 12; i++) begin
      stepCycles(1);
      checkOutput("glitch3_clean", gpio_bus.CLEAN_OUT, 32'h0001);
      checkOutput("glitch3_edges", {gpio_bus.RISE, gpio_bus.FALL}, 32'h0);
      checkOutput("glitch3_pend", gpio_bus.IRQ_PEND, 32'h0001);
      if (i == 3) applyStimulus(16'h0001, 16'h0000, 16'h0000);
    end

    // 4-cycle pulse on bit 3 is accepted, then debounced back low
    applyStimulus(16'h0009, 16'h0000, 16'h0000);
    for (int i = 1; i <= 12; i++) begin
      stepCycles(1);
      checkOutput("pulse3_clean", gpio_bus.CLEAN_OUT,
                  (i >= 6 && i <= 9) ? 32'h0009 : 32'h0001);
      checkOutput("pulse3_rise", gpio_bus.RISE, (i == 6) ? 32'h0008 : 32'h0000);
      checkOutput("pulse3_fall", gpio_bus.FALL, (i == 10) ? 32'h0008 : 32'h0000);
      checkOutput("pulse3_pend", gpio_bus.IRQ_PEND, 32'h0001);
      if (i == 4) applyStimulus(16'h0001, 16'h0000, 16'h0000);
    end

    // Clear coinciding with a new FALL[0]: set wins; then a lone clear empties it
    applyStimulus(16'h0000, 16'h0001, 16'h0000);
    stepCycles(5);
    checkOutput("fall0_early_clean", gpio_bus.CLEAN_OUT, 32'h0001);
    applyStimulus(16'h0000, 16'h0001, 16'h0001);
    stepCycles(1);
    checkOutput("fall0_fall", gpio_bus.FALL, 32'h0001);
    checkOutput("fall0_clean", gpio_bus.CLEAN_OUT, 32'h0000);
    checkOutput("set_wins_pend", gpio_bus.IRQ_PEND, 32'h0001);
    applyStimulus(16'h0000, 16'h0001, 16'h0000);
    stepCycles(1);
    checkOutput("sticky_pend", gpio_bus.IRQ_PEND, 32'h0001);
    applyStimulus(16'h0000, 16'h0001, 16'h0001);
    stepCycles(1);
    checkOutput("clear_pend", gpio_bus.IRQ_PEND, 32'h0000);
    checkOutput("clear_irq_lag", gpio_bus.CHANGE_IRQ, 32'h1);
    applyStimulus(16'h0000, 16'h0001, 16'h0000);
    stepCycles(1);
    checkOutput("clear_irq", gpio_bus.CHANGE_IRQ, 32'h0);

    // Reset while bit 5 has counted to 2; a full window is needed after release
    applyStimulus(16'h0020, 16'hFFFF, 16'h0000);
    stepCycles(4);
    RESET = 1'b1;
    stepCycles(1);
    checkOutput("midreset_clean", gpio_bus.CLEAN_OUT, 32'h0);
    checkOutput("midreset_edges", {gpio_bus.RISE, gpio_bus.FALL}, 32'h0);
    checkOutput("midreset_pend", gpio_bus.IRQ_PEND, 32'h0);
    checkOutput("midreset_irq", gpio_bus.CHANGE_IRQ, 32'h0);
    RESET = 1'b0;
    stepCycles(5);
    checkOutput("rise5_early_clean", gpio_bus.CLEAN_OUT, 32'h0000);
    checkOutput("rise5_early_rise", gpio_bus.RISE, 32'h0000);
    stepCycles(1);
    checkOutput("rise5_clean", gpio_bus.CLEAN_OUT, 32'h0020);
    checkOutput("rise5_rise", gpio_bus.RISE, 32'h0020);
    checkOutput("rise5_pend", gpio_bus.IRQ_PEND, 32'h0020);

    // All bits together: rise to 0xFFFF, settle, then all fall in one cycle
    applyStimulus(16'hFFFF, 16'hFFFF, 16'h0000);
    stepCycles(6);
    checkOutput("all_rise", gpio_bus.RISE, 32'hFFDF);
    checkOutput("all_high_clean", gpio_bus.CLEAN_OUT, 32'hFFFF);
    checkOutput("all_high_pend", gpio_bus.IRQ_PEND, 32'hFFFF);
    stepCycles(2);
    applyStimulus(16'h0000, 16'hFFFF, 16'h0000);
    stepCycles(5);
    checkOutput("all_fall_early_clean", gpio_bus.CLEAN_OUT, 32'hFFFF);
    checkOutput("all_fall_early_fall", gpio_bus.FALL, 32'h0000);
    stepCycles(1);
    checkOutput("all_fall_clean", gpio_bus.CLEAN_OUT, 32'h0000);
    checkOutput("all_fall_fall", gpio_bus.FALL, 32'hFFFF);
    stepCycles(1);
    checkOutput("all_fall_end", gpio_bus.FALL, 32'h0000);
    checkOutput("all_fall_irq", gpio_bus.CHANGE_IRQ, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
